// File: rtl/cpu_mem_arbiter.sv
// Shares one variable-latency memory port between the CPU's instruction fetch and data access.
// Each pipeline step runs an optional data access, then a fetch, then releases the CPU for one clock.
module cpu_mem_arbiter #(
  parameter int             XLEN     = 32,
  parameter int             TIMEOUT  = 16,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IM_address,
  input  logic            IM_enable,
  output logic [XLEN-1:0] IM_out,
  input  logic [XLEN-1:0] DM_address,
  input  logic [XLEN-1:0] DM_in,
  input  logic            DM_enable,
  input  logic            DM_write,
  output logic [XLEN-1:0] DM_out,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            err
);

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_DATA    = 2'd1,
    ST_FETCH   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] im_out_q, im_out_d;
  logic [XLEN-1:0] dm_out_q, dm_out_d;
  logic            err_q, err_d;
  logic            timed_out;

  // Fetch is always requested each step, so the enable carries no information.
  logic unused_im_enable;
  assign unused_im_enable = IM_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      wait_cnt_q <= '0;
      im_out_q   <= '0;
      dm_out_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      im_out_q   <= im_out_d;
      dm_out_q   <= dm_out_d;
      err_q      <= err_d;
    end
  end

  // The wait counter only survives while an access keeps waiting; any state change clears it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    im_out_d   = im_out_q;
    dm_out_d   = dm_out_q;
    err_d      = err_q;
    stall      = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    timed_out  = (wait_cnt_q == WAIT_LAST);

    case (state_q)
      ST_ARB: begin
        state_d = DM_enable ? ST_DATA : ST_FETCH;
      end
      ST_DATA: begin
        mem_req   = 1'b1;
        mem_we    = DM_write;
        mem_addr  = DM_address;
        mem_wdata = DM_in;
        if (mem_ready) begin
          if (!DM_write) begin
            dm_out_d = mem_rdata;
          end
          state_d = ST_FETCH;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = IM_address;
        if (mem_ready) begin
          im_out_d = mem_rdata;
          state_d  = ST_RELEASE;
        end else if (timed_out) begin
          im_out_d = NOP_INST;
          err_d    = 1'b1;
          state_d  = ST_RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        stall   = 1'b0;
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  assign IM_out = im_out_q;
  assign DM_out = dm_out_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized self-checking bench for cpu_mem_arbiter: a step-level timeline model predicts
// every cycle of each pipeline step and one compare loop checks the DUT against it.
module tb_cpu_mem_arbiter;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IM_address, IM_out, DM_address, DM_in, DM_out;
  logic        IM_enable, DM_enable, DM_write, stall;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] im;
    logic [31:0] dm;
    logic        err;
  } exp_t;

  logic [31:0] cur_im, cur_dm;
  logic        cur_err;
  int          step_len;
  logic [31:0] rel_im, rel_dm;
  logic        rel_err;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.XLEN(32), .TIMEOUT(TO), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .IM_address(IM_address), .IM_enable(IM_enable), .IM_out(IM_out),
    .DM_address(DM_address), .DM_in(DM_in), .DM_enable(DM_enable),
    .DM_write(DM_write), .DM_out(DM_out), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  task automatic check_val(input string name, input int cyc,
                           input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e, input int cyc);
    check_val("stall",     cyc, 32'(stall),   32'(e.stall));
    check_val("mem_req",   cyc, 32'(mem_req), 32'(e.req));
    check_val("mem_we",    cyc, 32'(mem_we),  32'(e.we));
    check_val("mem_addr",  cyc, mem_addr,     e.addr);
    check_val("mem_wdata", cyc, mem_wdata,    e.wdata);
    check_val("IM_out",    cyc, IM_out,       e.im);
    check_val("DM_out",    cyc, DM_out,       e.dm);
    check_val("err",       cyc, 32'(err),     32'(e.err));
  endtask

  // Builds the expected cycle timeline of one step, then plays it against the DUT.
  // A latency >= TO means the memory never answers that access.
  task automatic applyStimulus(input bit dm_en, input bit wr,
                               input logic [31:0] dm_a, input logic [31:0] dm_d,
                               input logic [31:0] im_a, input int dlat, input int flat,
                               input logic [31:0] drd, input logic [31:0] frd);
    exp_t q[$];
    exp_t e;
    int   n;
    IM_address = im_a;
    DM_address = dm_a;
    DM_in      = dm_d;
    DM_enable  = dm_en;
    DM_write   = wr;

    e = '0;
    e.stall = 1'b1;
    e.im = cur_im; e.dm = cur_dm; e.err = cur_err;
    e.ready = ($urandom_range(0, 3) == 0);
    e.rdata = $urandom;
    q.push_back(e);

    if (dm_en) begin
      n = (dlat < TO) ? dlat + 1 : TO;
      for (int i = 0; i < n; i++) begin
        e = '0;
        e.stall = 1'b1; e.req = 1'b1; e.we = wr;
        e.addr = dm_a; e.wdata = dm_d;
        e.ready = (i == dlat);
        e.rdata = (i == dlat) ? drd : $urandom;
        e.im = cur_im; e.dm = cur_dm; e.err = cur_err;
        q.push_back(e);
      end
      if (dlat < TO) begin
        if (!wr) cur_dm = drd;
      end else begin
        cur_err = 1'b1;
      end
    end

    n = (flat < TO) ? flat + 1 : TO;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.stall = 1'b1; e.req = 1'b1;
      e.addr = im_a;
      e.ready = (i == flat);
      e.rdata = (i == flat) ? frd : $urandom;
      e.im = cur_im; e.dm = cur_dm; e.err = cur_err;
      q.push_back(e);
    end
    if (flat < TO) begin
      cur_im = frd;
    end else begin
      cur_im  = NOP;
      cur_err = 1'b1;
    end

    e = '0;
    e.im = cur_im; e.dm = cur_dm; e.err = cur_err;
    e.ready = ($urandom_range(0, 3) == 0);
    e.rdata = $urandom;
    q.push_back(e);

    step_len = 0;
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].ready;
      mem_rdata = q[i].rdata;
      #1;
      checkOutput(q[i], i);
      if (stall == 1'b0 && step_len == 0) begin
        step_len = i + 1;
        rel_im   = IM_out;
        rel_dm   = DM_out;
        rel_err  = err;
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic reset_mid_data();
    DM_enable  = 1'b1;
    DM_write   = 1'b1;
    DM_address = 32'h00000080;
    DM_in      = 32'hCAFEF00D;
    IM_address = 32'h10000100;
    mem_ready  = 1'b0;
    @(negedge clk); #1;
    check_val("mid_arb_req", 0, 32'(mem_req), 32'd0);
    @(negedge clk); #1;
    check_val("mid_data_req",  1, 32'(mem_req), 32'd1);
    check_val("mid_data_addr", 1, mem_addr, 32'h00000080);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_req",   2, 32'(mem_req), 32'd0);
    check_val("rst_stall", 2, 32'(stall),   32'd1);
    check_val("rst_addr",  2, mem_addr,     32'd0);
    check_val("rst_we",    2, 32'(mem_we),  32'd0);
    check_val("rst_im",    2, IM_out,       32'd0);
    check_val("rst_dm",    2, DM_out,       32'd0);
    check_val("rst_err",   2, 32'(err),     32'd0);
    cur_im = '0; cur_dm = '0; cur_err = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  initial begin
    int dl, fl;
    rst_n      = 1'b1;
    IM_enable  = 1'b1;
    IM_address = 32'h10000000;
    DM_address = '0;
    DM_in      = '0;
    DM_enable  = 1'b0;
    DM_write   = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    cur_im = '0; cur_dm = '0; cur_err = 1'b0;
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_val("reset_stall", i, 32'(stall),   32'd1);
      check_val("reset_req",   i, 32'(mem_req), 32'd0);
      check_val("reset_im",    i, IM_out,       32'd0);
    end
    release_reset();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h10000000, 0, 0, 32'h0, 32'h00500093);
      check_val("fetch_only_len", i, 32'(step_len), 32'd3);
      check_val("fetch_only_im",  i, rel_im, 32'h00500093);
    end

    applyStimulus(1'b1, 1'b0, 32'h00000040, 32'h0, 32'h10000004, 2, 0,
                  32'hDEADBEEF, 32'h00100113);
    check_val("load_len", 0, 32'(step_len), 32'd6);
    check_val("load_dm",  0, rel_dm, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 32'h00000044, 32'h12345678, 32'h10000008, 0, 0,
                  32'h0BADF00D, 32'h00200193);
    check_val("store_len", 0, 32'(step_len), 32'd4);
    check_val("store_dm",  0, rel_dm, 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000000C, 255, 255, 32'h0, 32'h0);
    check_val("timeout_len", 0, 32'(step_len), 32'(TO + 2));
    check_val("timeout_im",  0, rel_im, NOP);
    check_val("timeout_err", 0, 32'(rel_err), 32'd1);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h10000010, 1, 1, 32'h0, 32'h00300213);
    check_val("err_sticky", 0, 32'(rel_err), 32'd1);
    check_val("after_to_im", 0, rel_im, 32'h00300213);

    for (int s = 0; s < 60; s++) begin
      dl = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
      fl = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
      applyStimulus(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                    $urandom & 32'hFFFF_FFFC, dl, fl, $urandom, $urandom);
    end

    reset_mid_data();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h10000000, 0, 0, 32'h0, 32'h00500093);
    check_val("restart_len", 0, 32'(step_len), 32'd3);
    check_val("restart_im",  0, rel_im, 32'h00500093);
    check_val("restart_err", 0, 32'(rel_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
